// File: rtl/rotary_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : rotary_input_conditioner
//  Purpose  : Synchronises and debounces the rotary encoder A/B/centre pins
//             against a shared tick prescaler. Drives clean levels to the
//             downstream position counter and generates press/release/
//             long-press strobes.
//  Revision : 1.0  initial release
// ============================================================================
module rotary_input_conditioner #(
  parameter int unsigned TICK_DIV         = 50000,
  parameter int unsigned STABLE_TICKS     = 3,
  parameter int unsigned LONG_PRESS_TICKS = 500,
  parameter logic [2:0]  INVERT           = 3'b000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_A,
  input  logic raw_B,
  input  logic raw_center,
  output logic rot_A,
  output logic rot_B,
  output logic rot_center,
  output logic center_press,
  output logic center_release,
  output logic center_long,
  output logic tick
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STAB_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int unsigned HOLD_W = 16;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_TICKS);

  // --------------------------------------------------------------------------
  // Input polarity normalisation and two-flop synchroniser, {center,B,A}
  // --------------------------------------------------------------------------
  logic [2:0] norm_w;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  assign norm_w = {raw_center, raw_B, raw_A} ^ INVERT;

  // Two-stage synchroniser for the asynchronous pins
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= norm_w;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce timebase
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick_w;

  assign tick_w = (div_q == DIV_LAST);

  // Free-running prescaler wrapping at TICK_DIV-1
  always_comb begin
    div_d = div_q + 1'b1;
    if (tick_w) begin
      div_d = '0;
    end
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce: the clean level flips only after STABLE_TICKS
  // consecutive ticks of disagreement; any agreement restarts the count.
  // --------------------------------------------------------------------------
  logic [2:0] clean_w;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic              clean_q;
    logic              clean_d;

    // Next-state for the stability counter and clean level
    always_comb begin
      stab_d  = stab_q;
      clean_d = clean_q;
      if (sync2_q[gi] == clean_q) begin
        stab_d = '0;
      end else if (tick_w) begin
        if (stab_q == STAB_LAST) begin
          clean_d = sync2_q[gi];
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
      if (rst) begin
        stab_q  <= '0;
        clean_q <= 1'b0;
      end else begin
        stab_q  <= stab_d;
        clean_q <= clean_d;
      end
    end

    assign clean_w[gi] = clean_q;
  end

  // --------------------------------------------------------------------------
  // Centre button strobes and long-press detection
  // --------------------------------------------------------------------------
  logic              clean_c_w;
  logic              prev_c_q;
  logic              press_q;
  logic              press_d;
  logic              release_q;
  logic              release_d;
  logic              long_q;
  logic              long_d;
  logic              fired_q;
  logic              fired_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  assign clean_c_w = clean_w[2];

  // Edge strobes, hold counter and one-shot long-press logic. The hold
  // counter sees the pre-flip (low) level on the flip cycle, so a tick in
  // that cycle is not counted.
  always_comb begin
    press_d   = clean_c_w & ~prev_c_q;
    release_d = ~clean_c_w & prev_c_q;
    long_d    = (hold_q == HOLD_MAX) && !fired_q;
    hold_d    = hold_q;
    fired_d   = fired_q;
    if (!clean_c_w) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else begin
      if (hold_q == HOLD_MAX) begin
        fired_d = 1'b1;
      end
      if (tick_w && (hold_q != HOLD_MAX)) begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // Strobe and hold-tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_c_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      fired_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      prev_c_q  <= clean_c_w;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      fired_q   <= fired_d;
      hold_q    <= hold_d;
    end
  end

  assign rot_A          = clean_w[0];
  assign rot_B          = clean_w[1];
  assign rot_center     = clean_w[2];
  assign center_press   = press_q;
  assign center_release = release_q;
  assign center_long    = long_q;
  assign tick           = tick_w;

endmodule
`default_nettype wire
